// File: rtl/song_reader.sv
// song_reader: steps through one song stored in an external registered-read ROM.
// Each ROM word holds a note code [14:9] and a duration in beats [8:3]; a zero
// duration marks the end of the song. Every note is held for its duration,
// counted in beat ticks while play is high, and then the next word is fetched.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   play       level: high runs/continues, low pauses (or releases DONE)
//   song       song select, latched when a song starts
//   beat       single-cycle duration tick
//   rom_addr   registered ROM address {song, index}
//   rom_dout   ROM word, valid one clock after rom_addr
//   note       current note code (0 = rest)
//   duration   current note length in beats
//   new_note   one-cycle pulse when note/duration are loaded
//   song_done  one-cycle pulse when the song ends
//   busy       high whenever the reader is not idle
module song_reader #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             play,
  input  logic [6-IDX_W:0] song,
  input  logic             beat,
  output logic [6:0]       rom_addr,
  input  logic [15:0]      rom_dout,
  output logic [5:0]       note,
  output logic [5:0]       duration,
  output logic             new_note,
  output logic             song_done,
  output logic             busy
);

  localparam int SONG_W = 7 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_PLAY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [5:0] word_note(input logic [15:0] w);
    return w[14:9];
  endfunction

  function automatic logic [5:0] word_dur(input logic [15:0] w);
    return w[8:3];
  endfunction

  state_t              state_r, state_s;
  logic [SONG_W-1:0]   song_r, song_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [IDX_W-1:0]    idx_inc_s;
  logic [5:0]          cnt_r, cnt_s;
  logic [6:0]          rom_addr_r, rom_addr_s;
  logic [5:0]          note_r, note_s;
  logic [5:0]          dur_r, dur_s;
  logic                new_note_r, new_note_s;
  logic                song_done_r, song_done_s;
  logic                busy_r, busy_s;
  logic                beat_hit_s;
  logic                last_beat_s;

  // Only beats seen in PLAY while running are counted; all others are dropped.
  assign beat_hit_s  = (state_r == S_PLAY) && play && beat;
  assign last_beat_s = beat_hit_s && (cnt_r == 6'd1);
  assign idx_inc_s   = idx_r + IDX_W'(1);

  assign rom_addr  = rom_addr_r;
  assign note      = note_r;
  assign duration  = dur_r;
  assign new_note  = new_note_r;
  assign song_done = song_done_r;
  assign busy      = busy_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  state_s = play ? S_FETCH : S_IDLE;
      S_FETCH: state_s = S_LATCH;
      S_LATCH: state_s = (word_dur(rom_dout) == 6'd0) ? S_DONE : S_PLAY;
      S_PLAY: begin
        if (last_beat_s) begin
          // The last index has no successor: the song ends instead of wrapping.
          state_s = (idx_r == LAST_IDX) ? S_DONE : S_FETCH;
        end else begin
          state_s = S_PLAY;
        end
      end
      S_DONE:  state_s = play ? S_DONE : S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of the datapath registers and output pulses.
  always_comb begin
    song_s      = song_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    rom_addr_s  = rom_addr_r;
    note_s      = note_r;
    dur_s       = dur_r;
    new_note_s  = 1'b0;
    song_done_s = 1'b0;
    busy_s      = (state_s != S_IDLE);
    case (state_r)
      S_IDLE: begin
        idx_s = {IDX_W{1'b0}};
        if (play) begin
          song_s     = song;
          rom_addr_s = {song, {IDX_W{1'b0}}};
        end else begin
          song_s = song_r;
        end
      end
      S_FETCH: begin
        cnt_s = cnt_r;
      end
      S_LATCH: begin
        if (word_dur(rom_dout) == 6'd0) begin
          note_s      = 6'd0;
          dur_s       = 6'd0;
          song_done_s = 1'b1;
        end else begin
          note_s     = word_note(rom_dout);
          dur_s      = word_dur(rom_dout);
          cnt_s      = word_dur(rom_dout);
          new_note_s = 1'b1;
        end
      end
      S_PLAY: begin
        if (beat_hit_s) begin
          cnt_s = cnt_r - 6'd1;
          if (last_beat_s && (idx_r == LAST_IDX)) begin
            note_s      = 6'd0;
            dur_s       = 6'd0;
            song_done_s = 1'b1;
          end else if (last_beat_s) begin
            idx_s      = idx_inc_s;
            rom_addr_s = {song_r, idx_inc_s};
          end else begin
            idx_s = idx_r;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_DONE: begin
        note_s = 6'd0;
        dur_s  = 6'd0;
      end
      default: begin
        idx_s = {IDX_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      song_r      <= {SONG_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      cnt_r       <= 6'd0;
      rom_addr_r  <= 7'd0;
      note_r      <= 6'd0;
      dur_r       <= 6'd0;
      new_note_r  <= 1'b0;
      song_done_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      song_r      <= song_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      rom_addr_r  <= rom_addr_s;
      note_r      <= note_s;
      dur_r       <= dur_s;
      new_note_r  <= new_note_s;
      song_done_r <= song_done_s;
      busy_r      <= busy_s;
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: a registered-read ROM, an event-level
// reference model compared on every falling edge, and directed scenarios with
// hand-computed expectations followed by a randomized run.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        beat;
  logic [6:0]  rom_addr;
  logic [15:0] rom_dout;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;
  logic        busy;

  logic [15:0] rom [0:127];

  int tests = 0;
  int fails = 0;
  int nn_cnt = 0;
  int sd_cnt = 0;

  // Reference model: note playback described as "fetch in flight" / "beats left".
  bit         m_active = 1'b0;
  bit         m_finished = 1'b0;
  int         m_wait = 0;
  int         m_idx = 0;
  int         m_left = 0;
  int         m_song = 0;
  logic [6:0] m_addr = 7'd0;
  logic [5:0] m_note = 6'd0;
  logic [5:0] m_dur = 6'd0;
  bit         m_nn = 1'b0;
  bit         m_sd = 1'b0;

  song_reader #(.IDX_W(5)) dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .beat(beat),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .note(note), .duration(duration),
    .new_note(new_note), .song_done(song_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered-read ROM.
  always @(posedge clk) rom_dout <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_finished = 1'b0; m_wait = 0; m_idx = 0; m_left = 0;
    m_song = 0; m_addr = 7'd0; m_note = 6'd0; m_dur = 6'd0; m_nn = 1'b0; m_sd = 1'b0;
  endtask

  task automatic model_finish();
    m_finished = 1'b1; m_note = 6'd0; m_dur = 6'd0; m_sd = 1'b1;
  endtask

  task automatic model_step();
    logic [15:0] w;
    m_nn = 1'b0;
    m_sd = 1'b0;
    if (!m_active) begin
      if (play) begin
        m_active = 1'b1; m_song = int'(song); m_idx = 0;
        m_addr = 7'(m_song * 32); m_wait = 2;
      end
    end else if (m_finished) begin
      if (!play) begin
        m_active = 1'b0; m_finished = 1'b0;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        w = rom[m_addr];
        if (w[8:3] == 6'd0) model_finish();
        else begin
          m_note = w[14:9]; m_dur = w[8:3]; m_left = int'(w[8:3]); m_nn = 1'b1;
        end
      end
    end else if (play && beat) begin
      m_left--;
      if (m_left == 0) begin
        if (m_idx == 31) model_finish();
        else begin
          m_idx++; m_addr = 7'(m_song * 32 + m_idx); m_wait = 2;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  // Compare DUT outputs against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("note", 32'(note), 32'(m_note));
    check("duration", 32'(duration), 32'(m_dur));
    check("new_note", 32'(new_note), 32'(m_nn));
    check("song_done", 32'(song_done), 32'(m_sd));
    check("busy", 32'(busy), 32'(m_active));
  end

  // Pulse counters, sampled just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (new_note) nn_cnt++;
    if (song_done) sd_cnt++;
  end

  task automatic fill_song(input int s, input int dmin, input int dmax);
    logic [15:0] w;
    for (int i = 0; i < 32; i++) begin
      w = 16'($urandom);
      w[8:3] = 6'($urandom_range(dmin, dmax));
      rom[s * 32 + i] = w;
    end
  endtask

  task automatic fill_random();
    logic [15:0] w;
    for (int i = 0; i < 128; i++) begin
      w = 16'($urandom);
      w[8:3] = ($urandom_range(0, 11) == 0) ? 6'd0 : 6'($urandom_range(1, 4));
      rom[i] = w;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    play = 1'b0; beat = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int nn0;
    int sd0;
    logic [15:0] w;
    reset = 1'b1; play = 1'b0; beat = 1'b0; song = 2'd0;
    model_reset();
    fill_random();
    repeat (2) @(negedge clk);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_note", 32'(note), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // First note of song 0: latency, fields, and advance after the 12th beat.
    fill_song(0, 1, 3);
    rom[0] = {1'b0, 6'd49, 6'd12, 3'd0};
    w = rom[28]; w[8:3] = 6'd0; rom[28] = w;
    play = 1'b1; song = 2'd0;
    n = 0;
    while (!new_note && n < 10) begin @(negedge clk); n++; end
    check("start_latency", 32'(n), 32'd3);
    check("first_note", 32'(note), 32'd49);
    check("first_duration", 32'(duration), 32'd12);
    for (int k = 1; k <= 12; k++) begin
      repeat (3) @(negedge clk);
      beat = 1'b1;
      @(negedge clk);
      beat = 1'b0;
      if (k == 11) check("addr_before_12th", 32'(rom_addr), 32'd0);
    end
    check("addr_after_12th", 32'(rom_addr), 32'd1);

    // Walk to the end marker at index 28 with random beats and pauses.
    sd0 = sd_cnt;
    n = 0;
    while (!song_done && n < 3000) begin
      @(negedge clk); n++;
      beat = ($urandom_range(0, 1) == 1);
      play = ($urandom_range(0, 7) != 0);
    end
    play = 1'b1; beat = 1'b1;
    check("end_marker_reached", 32'(n < 3000), 32'd1);
    repeat (10) @(negedge clk);
    check("end_marker_done_once", 32'(sd_cnt - sd0), 32'd1);
    check("end_marker_addr", 32'(rom_addr), 32'd28);
    check("done_note_zero", 32'(note), 32'd0);
    check("done_busy_high", 32'(busy), 32'd1);
    play = 1'b0; beat = 1'b0;
    @(negedge clk);
    check("idle_after_release", 32'(busy), 32'd0);

    // Song 3, all 32 entries one beat long: no wrap to the first entry.
    fill_song(3, 1, 1);
    nn0 = nn_cnt; sd0 = sd_cnt;
    play = 1'b1; song = 2'd3; beat = 1'b1;
    n = 0;
    while (!song_done && n < 400) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    check("song3_new_notes", 32'(nn_cnt - nn0), 32'd32);
    check("song3_done_once", 32'(sd_cnt - sd0), 32'd1);
    check("song3_last_addr", 32'(rom_addr), 32'd127);
    check("song3_busy", 32'(busy), 32'd1);
    play = 1'b0; beat = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while playing note index 5 of song 1.
    fill_song(1, 2, 4);
    play = 1'b1; song = 2'd1;
    n = 0;
    while (!(m_active && m_idx == 5 && m_wait == 0) && n < 2000) begin
      @(negedge clk); n++;
      beat = ($urandom_range(0, 1) == 1);
    end
    check("reached_note5", 32'(n < 2000), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rom_addr", 32'(rom_addr), 32'd0);
    check("async_note", 32'(note), 32'd0);
    check("async_duration", 32'(duration), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0; beat = 1'b0;
    @(negedge clk);
    check("restart_addr", 32'(rom_addr), 32'd32);
    do_reset();

    // Beat held high from play rising: only beats in PLAY count.
    w = rom[64]; w[8:3] = 6'd2; rom[64] = w;
    play = 1'b1; song = 2'd2; beat = 1'b1;
    repeat (3) @(negedge clk);
    check("beat_first_note", 32'(new_note), 32'd1);
    @(negedge clk);
    check("beat_still_first", 32'(rom_addr), 32'd64);
    @(negedge clk);
    check("beat_advance", 32'(rom_addr), 32'd65);
    do_reset();

    // Randomized run: random play, beats, song select and ROM refills while idle.
    fill_random();
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (!m_active && $urandom_range(0, 3) == 0) fill_random();
      play = ($urandom_range(0, 9) != 0);
      beat = ($urandom_range(0, 2) == 0);
      song = 2'($urandom_range(0, 3));
    end
    play = 1'b0; beat = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
